// File: rtl/alu_req_arbiter_if.sv
// Bus bundle between the two ALU requesters, the shared ALU_8bit and the response consumer.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface alu_req_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_op;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_op;
  logic [7:0]  req1_a, req1_b;
  logic [2:0]  alu_operation;
  logic [7:0]  alu_operand_A, alu_operand_B;
  logic [15:0] alu_result;
  logic        alu_carry_flag, alu_zero_flag;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_operation, alu_operand_A, alu_operand_B,
    input  alu_result, alu_carry_flag, alu_zero_flag,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_operation, alu_operand_A, alu_operand_B,
    output alu_result, alu_carry_flag, alu_zero_flag,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one combinational ALU_8bit between two requesters and returns a tagged response.
// Optional per-port completion counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_req_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]    ops_done0,
  output logic [15:0]    ops_done1
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

  state_t      r_state, w_next;
  logic        r_last, r_owner;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [7:0]  r_a, r_b;
  logic        r_rsp_vld, r_rsp_id, r_rsp_c, r_rsp_z;
  logic [15:0] r_rsp_res;

  logic [1:0]  w_vld;
  logic        w_gnt, w_fire, w_pop;

  assign w_vld = {bus.req1_valid, bus.req0_valid};

  // With both ports valid, the port that was not granted last wins. Otherwise the only valid port wins.
  always_comb begin
    w_gnt = w_vld[1];
    if (w_vld == 2'b11) w_gnt = ~r_last;
  end

  // Ready is gated by rst_n so that both ready outputs read 0 while reset is held.
  assign w_fire         = rst_n & (r_state == IDLE) & (|w_vld);
  assign w_pop          = (r_state == RESP) & bus.rsp_ready;
  assign bus.req0_ready = w_fire & ~w_gnt;
  assign bus.req1_ready = w_fire &  w_gnt;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_fire)          w_next = EXEC;
      EXEC:    if (r_cnt == 4'd0)   w_next = RESP;
      RESP:    if (bus.rsp_ready)   w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= 1'b0;
      r_rsp_res <= '0;
      r_rsp_c   <= 1'b0;
      r_rsp_z   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_op    <= w_gnt ? bus.req1_op : bus.req0_op;
        r_a     <= w_gnt ? bus.req1_a  : bus.req0_a;
        r_b     <= w_gnt ? bus.req1_b  : bus.req0_b;
        r_owner <= w_gnt;
        r_last  <= w_gnt;
        r_cnt   <= CNT_INIT;
      end
      if (r_state == EXEC) begin
        if (r_cnt == 4'd0) begin
          r_rsp_res <= bus.alu_result;
          r_rsp_c   <= bus.alu_carry_flag;
          r_rsp_z   <= bus.alu_zero_flag;
          r_rsp_id  <= r_owner;
          r_rsp_vld <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      // The payload registers keep their values after the pop. Only the valid bit drops.
      if (w_pop) r_rsp_vld <= 1'b0;
    end
  end

  assign bus.alu_operation = r_op;
  assign bus.alu_operand_A = r_a;
  assign bus.alu_operand_B = r_b;
  assign bus.rsp_valid     = r_rsp_vld;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_result    = r_rsp_res;
  assign bus.rsp_carry     = r_rsp_c;
  assign bus.rsp_zero      = r_rsp_z;

`ifdef ALU_ARB_STATS_EN
  logic [1:0][15:0] r_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops <= '0;
    end else if (w_pop && r_ops[r_rsp_id] != 16'hFFFF) begin
      r_ops[r_rsp_id] <= r_ops[r_rsp_id] + 16'd1;
    end
  end

  assign ops_done0 = r_ops[0];
  assign ops_done1 = r_ops[1];
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter. An ALU stub drives the result inputs, and a transaction-level model predicts every output each cycle.
module tb_alu_req_arbiter;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_req_arbiter_if bus_if();
`ifdef ALU_ARB_STATS_EN
  logic [15:0] ops_done0, ops_done1;
`endif

  alu_req_arbiter #(.ALU_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef ALU_ARB_STATS_EN
    ,
    .ops_done0 (ops_done0),
    .ops_done1 (ops_done1)
`endif
  );

  // ALU_8bit stand-in, packed as {zero, carry, result}
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      3'd0:    begin r = 16'(a) + 16'(b); c = r[8]; end
      3'd1:    begin r = {8'h00, a - b}; c = (a < b); end
      3'd2:    r = 16'(a) * 16'(b);
      3'd3:    r = {8'h00, a & b};
      3'd4:    r = {8'h00, a | b};
      3'd5:    r = {8'h00, ~(a & b)};
      3'd6:    r = {8'h00, ~(a | b)};
      default: r = {8'h00, a ^ b};
    endcase
    return {(r == 16'h0000), c, r};
  endfunction

  always_comb {bus_if.alu_zero_flag, bus_if.alu_carry_flag, bus_if.alu_result} =
    alu_f(bus_if.alu_operation, bus_if.alu_operand_A, bus_if.alu_operand_B);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight from the accept edge until its response is consumed
  int          cyc;
  int          m_acc;
  bit          m_busy, m_last, m_id;
  logic [17:0] m_rsp;
  logic [2:0]  m_op;
  logic [7:0]  m_a, m_b;
  bit          d_id;
  logic [17:0] d_rsp;
  int          cnt [2];
  bit          acc [2];
  int          gq   [$];
  int          dres [$];
  int          did  [$];
  int          dz   [$];

  bit          v  [2];
  logic [2:0]  op [2];
  logic [7:0]  a  [2];
  logic [7:0]  b  [2];
  bit          rr;

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_rsp = '0; m_acc = 0;
    m_op = '0; m_a = '0; m_b = '0;
    d_id = 1'b0; d_rsp = '0;
    cnt[0] = 0; cnt[1] = 0;
    acc[0] = 1'b0; acc[1] = 1'b0;
  endtask

  task automatic apply();
    bus_if.req0_valid = v[0]; bus_if.req0_op = op[0]; bus_if.req0_a = a[0]; bus_if.req0_b = b[0];
    bus_if.req1_valid = v[1]; bus_if.req1_op = op[1]; bus_if.req1_a = a[1]; bus_if.req1_b = b[1];
    bus_if.rsp_ready  = rr;
  endtask

  initial begin
    int   stall, and_idx, mode;
    bit   rst_done, post_rst, e_r0, e_r1, e_rv, gnt, p;
    logic [17:0] e_rsp;
    bit          e_id;
    for (int i = 0; i < 2; i++) begin v[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0; end
    rr = 1'b0; stall = 0; and_idx = -1; rst_done = 1'b0; post_rst = 1'b0; cyc = 0;
    apply();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_alu_op",    32'(bus_if.alu_operation), 32'd0);
    chk("rst_alu_a",     32'(bus_if.alu_operand_A), 32'd0);
    chk("rst_rsp_res",   32'(bus_if.rsp_result), 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      mode = (c < 24) ? 0 : (c < 40) ? 2 : 1;
      if (c == 40) and_idx = dres.size() - 1;
      for (int q = 0; q < 2; q++) begin
        if (mode == 0) begin
          // both ports keep re-requesting so the grants must alternate
          v[q] = 1'b1; op[q] = (q == 1) ? 3'd7 : 3'd2; a[q] = 8'hDA; b[q] = 8'h27;
        end else if (mode == 2) begin
          if (q == 0) v[0] = 1'b0;
          else if (c == 24) begin v[1] = 1'b1; op[1] = 3'd3; a[1] = 8'h0F; b[1] = 8'hF0; end
          else if (acc[1]) v[1] = 1'b0;
        end else if (post_rst) begin
          v[q] = 1'b1; op[q] = 3'($urandom); a[q] = 8'($urandom); b[q] = 8'($urandom);
        end else if (acc[q] || !v[q]) begin
          v[q] = ($urandom % 2) == 1; op[q] = 3'($urandom); a[q] = 8'($urandom); b[q] = 8'($urandom);
        end else if ($urandom % 20 == 0) begin
          v[q] = 1'b0;
        end
      end
      if (mode != 1)         rr = 1'b1;
      else if (stall > 0)    begin rr = 1'b0; stall--; end
      else if ($urandom % 25 == 0) begin rr = 1'b0; stall = 5; end
      else                   rr = ($urandom % 4) != 0;
      apply();

      if (mode == 1 && !rst_done && c >= 2000 && m_busy && (cyc - m_acc) < LAT) begin
        rst_done = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("mid_rst_rdy0",      32'(bus_if.req0_ready), 32'd0);
        chk("mid_rst_rdy1",      32'(bus_if.req1_ready), 32'd0);
        chk("mid_rst_alu",       32'({bus_if.alu_operation, bus_if.alu_operand_A, bus_if.alu_operand_B}), 32'd0);
        chk("mid_rst_rsp",       32'({bus_if.rsp_id, bus_if.rsp_carry, bus_if.rsp_zero, bus_if.rsp_result}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        post_rst = 1'b1;
        continue;
      end

      #1;
      e_rv = m_busy && (cyc - m_acc >= LAT);
      gnt  = (v[0] && v[1]) ? !m_last : v[1];
      e_r0 = !m_busy && v[0] && !gnt;
      e_r1 = !m_busy && v[1] && gnt;
      e_rsp = e_rv ? m_rsp : d_rsp;
      e_id  = e_rv ? m_id  : d_id;
      chk("req0_ready", 32'(bus_if.req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(bus_if.req1_ready), 32'(e_r1));
      chk("rsp_valid",  32'(bus_if.rsp_valid),  32'(e_rv));
      chk("rsp_id",     32'(bus_if.rsp_id),     32'(e_id));
      chk("rsp_result", 32'(bus_if.rsp_result), 32'(e_rsp[15:0]));
      chk("rsp_carry",  32'(bus_if.rsp_carry),  32'(e_rsp[16]));
      chk("rsp_zero",   32'(bus_if.rsp_zero),   32'(e_rsp[17]));
      chk("alu_inputs", 32'({bus_if.alu_operation, bus_if.alu_operand_A, bus_if.alu_operand_B}),
          32'({m_op, m_a, m_b}));
`ifdef ALU_ARB_STATS_EN
      chk("ops_done0", 32'(ops_done0), 32'(cnt[0]));
      chk("ops_done1", 32'(ops_done1), 32'(cnt[1]));
`endif
      if (post_rst) begin
        chk("rst_first_gnt_req0", 32'(bus_if.req0_ready), 32'd1);
        post_rst = 1'b0;
      end

      @(posedge clk);
      cyc++;
      acc[0] = 1'b0; acc[1] = 1'b0;
      if (e_r0 || e_r1) begin
        p      = e_r1;
        m_busy = 1'b1; m_acc = cyc; m_id = p; m_last = p;
        m_op = op[p]; m_a = a[p]; m_b = b[p];
        m_rsp  = alu_f(op[p], a[p], b[p]);
        acc[p] = 1'b1;
        gq.push_back(int'(p));
      end else if (e_rv && rr) begin
        m_busy = 1'b0; d_id = m_id; d_rsp = m_rsp;
        if (cnt[m_id] < 65535) cnt[m_id]++;
        dres.push_back(int'(m_rsp[15:0])); did.push_back(int'(m_id)); dz.push_back(int'(m_rsp[17]));
      end
    end

    // fixed-value checks on the opening directed traffic
    chk("grant_count", 32'(gq.size() >= 4 && dres.size() >= 2 && and_idx >= 0), 32'd1);
    if (gq.size() >= 4 && dres.size() >= 2 && and_idx >= 0) begin
      chk("grant_seq", 32'({gq[0][3:0], gq[1][3:0], gq[2][3:0], gq[3][3:0]}), 32'h0101);
      chk("first_mul", 32'(dres[0]), 32'h2136);
      chk("first_id",  32'(did[0]),  32'd0);
      chk("second_xor", 32'(dres[1]), 32'h00FD);
      chk("second_id", 32'(did[1]),  32'd1);
      chk("and_result", 32'(dres[and_idx]), 32'd0);
      chk("and_zero",   32'(dz[and_idx]),   32'd1);
      chk("and_id",     32'(did[and_idx]),  32'd1);
    end
    chk("mid_reset_hit", 32'(rst_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational ALU_8bit between two requesters (port 0, port 1) using valid/ready handshakes.
- Round-robin grant; registers the granted operation and operands onto the ALU inputs.
- Waits ALU_LATENCY cycles, then captures result/carry/zero into a single response channel tagged with the requester id.
- Sits between the datapath clients and the ALU_8bit instance.

Parameters:
- ALU_LATENCY, 1, cycles between driving ALU inputs and capturing its outputs; legal 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  3  ALU operation code (000 ADD … 111 XOR).
- req0_a  in  8  operand A.
- req0_b  in  8  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as the req0_* ports, for requester 1.
- alu_operation  out  3  registered to ALU operation.
- alu_operand_A  out  8  registered to ALU operand_A.
- alu_operand_B  out  8  registered to ALU operand_B.
- alu_result  in  16  from ALU result.
- alu_carry_flag  in  1  from ALU carry_flag.
- alu_zero_flag  in  1  from ALU zero_flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  16  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zero  out  1  captured zero.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=1 (so req0 wins first), wait counter=0.
  - alu_operation, alu_operand_A and alu_operand_B = 0.
  - rsp_valid, rsp_id, rsp_result, rsp_carry and rsp_zero = 0.
  - req0_ready and req1_ready = 0.
- Grant (combinational, IDLE only):
  - If exactly one reqN_valid, grant N.
  - If both are valid, grant the port that is not last_grant.
  - reqN_ready = (state==IDLE) & granted N & reqN_valid.
  - Ready is 0 in all other states.
- IDLE: when a valid&ready handshake occurs at an edge:
  - load alu_* from the granted port;
  - owner<=N, counter<=ALU_LATENCY-1;
  - last_grant<=N; go to EXEC.
  - With no valid input, stay in IDLE.
- EXEC: ALU inputs held stable.
  - If counter==0: rsp_result/carry/zero <= alu_* inputs, rsp_id<=owner, rsp_valid<=1, go to RESP.
  - Otherwise decrement the counter.
- RESP: rsp_* held stable while rsp_valid & !rsp_ready. On rsp_ready:
  - rsp_valid<=0, go to IDLE;
  - rsp_result/flags retain their last values.
- Latency:
  - rsp_valid rises exactly ALU_LATENCY cycles after the accept edge.
  - The earliest next accept is the edge after the response is consumed.
  - Maximum throughput is 1 op per ALU_LATENCY+2 cycles.
- Requesters must hold valid/op/a/b stable until ready; a dropped valid before ready is legal and issues nothing.
- Width rules:
  - Result and flags are passed through unmodified; no arithmetic inside the block.
  - alu_operation and operands change only on an accept edge.
- Simultaneous events:
  - A request arriving in EXEC or RESP waits; no buffering, no drop.
  - rsp_ready asserted with rsp_valid=0 is ignored.
- Reset mid-operation (any state): immediately return to the reset values.
  - The in-flight op is discarded and no response is produced.
  - last_grant returns to 1.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, two extra outputs are added:
  - ops_done0 (16): completed responses for port 0;
  - ops_done1 (16): completed responses for port 1.
- Counter behaviour:
  - A counter increments on the rsp_valid&rsp_ready edge for its rsp_id.
  - Counters saturate at 0xFFFF.
  - Counters reset to 0 on rst_n.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. req0 only, op=000, A=0xDA, B=0x27, rsp_ready=1, ALU_LATENCY=1 -> req0_ready 1 cycle; rsp_valid 1 cycle after accept; rsp_id=0, rsp_result=0x0101.
2. Both valid from reset: req0 MUL 0xDA×0x27, req1 XOR 0xDA^0x27 -> first rsp_id=0 result 0x2136, second rsp_id=1 result 0x00FD; keep both valid -> grants alternate 0,1,0,1.
3. rsp_ready low 5 cycles while in RESP with req1 valid -> rsp_* stable, req1_ready stays 0; req1 accepted on the edge after rsp_ready rises plus one cycle.
4. ALU_LATENCY=3, req1 AND 0x0F,0xF0 -> alu_* stable 3 cycles; rsp_valid exactly 3 cycles after accept; rsp_result=0, rsp_zero=1.
5. rst_n asserted during EXEC -> all outputs 0 asynchronously, no rsp_valid; after release, a simultaneous req0/req1 grants req0.
6. ALU_ARB_STATS_EN defined, 3 port-0 ops and 2 port-1 ops -> ops_done0=3, ops_done1=2; counters preset to 0xFFFF remain 0xFFFF after a further op.
